// File: rtl/trdb_pkg.sv
// Shared types for the trace-debugger capture path: the captured sample
// record, the capture FSM encoding and the trigger address compare.
package trdb_pkg;

    typedef struct packed {
        logic        lost_before;
        logic        valid;
        logic        exception;
        logic        interrupt;
        logic [4:0]  cause;
        logic [31:0] tval;
        logic [2:0]  priv;
        logic        compressed;
        logic [31:0] iaddr;
        logic [31:0] instr;
    } trdb_sample_t;

    localparam int unsigned SAMPLE_W = $bits(trdb_sample_t);

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_TRACING = 2'd2,
        CAP_DRAIN   = 2'd3
    } trdb_cap_state_e;

    // Instruction addresses are at least halfword aligned, so bit 0 is ignored.
    function automatic logic addr_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:1] == b[31:1];
    endfunction

endpackage

// File: rtl/trdb_sample_fifo.sv
// Small synchronous FIFO with first-word fall-through from the registered head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trdb_sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = empty_o ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count marks which entries are live and
    // data_o is forced to zero while empty, so stale contents never escape.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/trdb_capture_ctrl.sv
// Capture sequencer: qualifies retirements with enable and start/stop address
// triggers, buffers samples and counts those lost to consumer back-pressure.
module trdb_capture_ctrl
    import trdb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LOST_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ivalid_i,
    input  logic                  iexception_i,
    input  logic                  interrupt_i,
    input  logic [4:0]            cause_i,
    input  logic [31:0]           tval_i,
    input  logic [2:0]            priv_i,
    input  logic [31:0]           iaddr_i,
    input  logic [31:0]           instr_i,
    input  logic                  compressed_i,
    input  logic                  enable_i,
    input  logic                  trig_start_en_i,
    input  logic [31:0]           trig_start_addr_i,
    input  logic                  trig_stop_en_i,
    input  logic [31:0]           trig_stop_addr_i,
    input  logic                  clr_lost_i,
    output trdb_sample_t          sample_o,
    output logic                  sample_valid_o,
    input  logic                  sample_ready_i,
    output logic                  lost_o,
    output logic [LOST_CNT_W-1:0] lost_cnt_o,
    output trdb_cap_state_e       state_o
);

    trdb_cap_state_e state;
    trdb_sample_t    push_sample;
    logic [SAMPLE_W-1:0] fifo_data;
    logic q;
    logic start_hit;
    logic stop_hit;
    logic push;
    logic pop;
    logic drop;
    logic fifo_full;
    logic fifo_empty;
    logic pending_lost;

    assign q         = ivalid_i | iexception_i;
    assign start_hit = q & trig_start_en_i & addr_match(iaddr_i, trig_start_addr_i);
    assign stop_hit  = q & trig_stop_en_i & addr_match(iaddr_i, trig_stop_addr_i);

    assign sample_valid_o = ~fifo_empty;
    assign pop            = sample_valid_o & sample_ready_i;
    assign drop           = push & fifo_full & ~pop;
    assign state_o        = state;
    assign sample_o       = trdb_sample_t'(fifo_data);

    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        push = 1'b0;
        case (state)
            CAP_ARMED:   push = enable_i & start_hit;
            CAP_TRACING: push = enable_i & q;
            default:     push = 1'b0;
        endcase
    end

    always_comb begin
        push_sample             = '0;
        push_sample.lost_before = pending_lost;
        push_sample.valid       = ivalid_i;
        push_sample.exception   = iexception_i;
        push_sample.interrupt   = interrupt_i;
        push_sample.cause       = cause_i;
        push_sample.tval        = iexception_i ? tval_i : 32'h0;
        push_sample.priv        = priv_i;
        push_sample.compressed  = compressed_i;
        push_sample.iaddr       = iaddr_i;
        push_sample.instr       = instr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= CAP_IDLE;
        end else begin
            case (state)
                CAP_IDLE: begin
                    if (enable_i) state <= CAP_ARMED;
                end
                CAP_ARMED: begin
                    if (!enable_i)             state <= CAP_IDLE;
                    else if (!trig_start_en_i) state <= CAP_TRACING;
                    else if (start_hit)        state <= stop_hit ? CAP_DRAIN : CAP_TRACING;
                end
                CAP_TRACING: begin
                    if (!enable_i || stop_hit) state <= CAP_DRAIN;
                end
                CAP_DRAIN: begin
                    if (fifo_empty) state <= enable_i ? CAP_ARMED : CAP_IDLE;
                end
                default: state <= CAP_IDLE;
            endcase
        end
    end

    // A clear coinciding with a drop still records that drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_lost <= 1'b0;
            lost_o       <= 1'b0;
            lost_cnt_o   <= '0;
        end else begin
            if (drop)      pending_lost <= 1'b1;
            else if (push) pending_lost <= 1'b0;

            if (clr_lost_i) begin
                lost_o     <= drop;
                lost_cnt_o <= drop ? LOST_CNT_W'(1) : '0;
            end else if (drop) begin
                lost_o <= 1'b1;
                if (lost_cnt_o != '1) lost_cnt_o <= lost_cnt_o + LOST_CNT_W'(1);
            end
        end
    end

    trdb_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_sample),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_trdb_capture_ctrl.sv
// Directed bench for trdb_capture_ctrl: trigger sequencing, latency, overflow
// accounting, counter saturation (second instance) and asynchronous reset.
module tb_trdb_capture_ctrl;
    import trdb_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            ivalid_i, iexception_i, interrupt_i, compressed_i;
    logic [4:0]      cause_i;
    logic [31:0]     tval_i, iaddr_i, instr_i;
    logic [2:0]      priv_i;
    logic            enable_i, trig_start_en_i, trig_stop_en_i, clr_lost_i;
    logic [31:0]     trig_start_addr_i, trig_stop_addr_i;
    logic            sample_ready_i;
    trdb_sample_t    sample_o, sample2;
    logic            sample_valid_o, valid2;
    logic            lost_o, lost2;
    logic [15:0]     lost_cnt_o;
    logic [1:0]      lost_cnt2;
    trdb_cap_state_e state_o, state2;

    int n_tests = 0;
    int n_fail  = 0;
    trdb_sample_t got[$];

    always #5 clk_i = ~clk_i;

    trdb_capture_ctrl #(.FIFO_DEPTH(4), .LOST_CNT_W(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ivalid_i(ivalid_i), .iexception_i(iexception_i),
        .interrupt_i(interrupt_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
        .iaddr_i(iaddr_i), .instr_i(instr_i), .compressed_i(compressed_i), .enable_i(enable_i),
        .trig_start_en_i(trig_start_en_i), .trig_start_addr_i(trig_start_addr_i),
        .trig_stop_en_i(trig_stop_en_i), .trig_stop_addr_i(trig_stop_addr_i),
        .clr_lost_i(clr_lost_i), .sample_o(sample_o), .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i), .lost_o(lost_o), .lost_cnt_o(lost_cnt_o),
        .state_o(state_o)
    );

    trdb_capture_ctrl #(.FIFO_DEPTH(4), .LOST_CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .ivalid_i(ivalid_i), .iexception_i(iexception_i),
        .interrupt_i(interrupt_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
        .iaddr_i(iaddr_i), .instr_i(instr_i), .compressed_i(compressed_i), .enable_i(enable_i),
        .trig_start_en_i(trig_start_en_i), .trig_start_addr_i(trig_start_addr_i),
        .trig_stop_en_i(trig_stop_en_i), .trig_stop_addr_i(trig_stop_addr_i),
        .clr_lost_i(clr_lost_i), .sample_o(sample2), .sample_valid_o(valid2),
        .sample_ready_i(sample_ready_i), .lost_o(lost2), .lost_cnt_o(lost_cnt2),
        .state_o(state2)
    );

    // Records every sample the consumer accepts; handshake is stable at negedge.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && sample_valid_o && sample_ready_i) got.push_back(sample_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic retire(input logic [31:0] addr);
        ivalid_i = 1'b1;
        iaddr_i  = addr;
        instr_i  = 32'h0000_0013 ^ addr;
    endtask

    task automatic check_state(input string name, input trdb_cap_state_e exp);
        n_tests++;
        if (state_o !== exp) begin
            n_fail++;
            $display("FAIL %s: state=%0d expected %0d", name, state_o, exp);
        end
    endtask

    task automatic check_got(input string name, input logic [31:0] exp_addr[$], input logic exp_lb[$]);
        n_tests++;
        if (got.size() != exp_addr.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d samples expected %0d", name, got.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                n_tests++;
                if (got[i].iaddr !== exp_addr[i] || got[i].lost_before !== exp_lb[i]) begin
                    n_fail++;
                    $display("FAIL %s_%0d: addr=%h lost_before=%b expected addr=%h lost_before=%b",
                             name, i, got[i].iaddr, got[i].lost_before, exp_addr[i], exp_lb[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (sample_valid_o !== 1'b0 || sample_o !== '0 || lost_o !== 1'b0 ||
            lost_cnt_o !== 16'd0 || state_o !== CAP_IDLE) begin
            n_fail++;
            $display("FAIL reset: valid=%b sample=%h lost=%b cnt=%0d state=%0d expected all zero",
                     sample_valid_o, sample_o, lost_o, lost_cnt_o, state_o);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] exp;
        enable_i = 1'b1;
        tick();
        check_state("free_armed", CAP_ARMED);
        tick();
        check_state("free_tracing", CAP_TRACING);
        tval_i = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            exp = 32'h100 + 32'(4 * i);
            retire(exp);
            tick();
            n_tests++;
            if (sample_valid_o !== 1'b1 || sample_o.iaddr !== exp || sample_o.tval !== 32'h0 ||
                sample_o.valid !== 1'b1 || sample_o.lost_before !== 1'b0) begin
                n_fail++;
                $display("FAIL free_out%0d: valid=%b addr=%h tval=%h vbit=%b expected 1 %h 0 1",
                         i, sample_valid_o, sample_o.iaddr, sample_o.tval, sample_o.valid, exp);
            end
        end
        ivalid_i = 1'b0;
        tick();
        n_tests++;
        if (sample_valid_o !== 1'b0 || lost_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL free_end: valid=%b cnt=%0d expected 0 0", sample_valid_o, lost_cnt_o);
        end
        enable_i = 1'b0;
        tick();
        check_state("free_drain", CAP_DRAIN);
        enable_i          = 1'b1;
        trig_start_en_i   = 1'b1;
        trig_start_addr_i = 32'h200;
        tick();
        check_state("rearm", CAP_ARMED);
    endtask

    task automatic test_start_trigger();
        logic [31:0] addrs[4] = '{32'h1F0, 32'h1F8, 32'h200, 32'h204};
        trdb_cap_state_e exp_st[4] = '{CAP_ARMED, CAP_ARMED, CAP_TRACING, CAP_TRACING};
        got.delete();
        for (int i = 0; i < 4; i++) begin
            retire(addrs[i]);
            tick();
            check_state($sformatf("start_st%0d", i), exp_st[i]);
        end
        ivalid_i = 1'b0;
        tick();
        check_got("start_out", '{32'h200, 32'h204}, '{1'b0, 1'b0});
    endtask

    task automatic test_stop_trigger();
        trig_stop_en_i   = 1'b1;
        trig_stop_addr_i = 32'h301;
        got.delete();
        retire(32'h2FC);
        tick();
        check_state("stop_pre", CAP_TRACING);
        retire(32'h300);
        tick();
        check_state("stop_hit", CAP_DRAIN);
        retire(32'h304);
        tick();
        check_state("stop_drain", CAP_DRAIN);
        n_tests++;
        if (sample_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_no_push: valid=%b expected 0", sample_valid_o);
        end
        ivalid_i = 1'b0;
        tick();
        check_state("stop_rearm", CAP_ARMED);
        check_got("stop_out", '{32'h2FC, 32'h300}, '{1'b0, 1'b0});
    endtask

    task automatic test_overflow();
        trig_start_en_i = 1'b0;
        trig_stop_en_i  = 1'b0;
        tick();
        check_state("ovf_tracing", CAP_TRACING);
        sample_ready_i = 1'b0;
        got.delete();
        for (int i = 0; i < 7; i++) begin
            retire(32'h400 + 32'(4 * i));
            tick();
        end
        ivalid_i = 1'b0;
        tick();
        tick();
        n_tests++;
        if (lost_cnt_o !== 16'd3 || lost_o !== 1'b1 || lost_cnt2 !== 2'd3 ||
            sample_valid_o !== 1'b1 || sample_o.iaddr !== 32'h400) begin
            n_fail++;
            $display("FAIL ovf_hold: cnt=%0d lost=%b cnt2=%0d valid=%b head=%h expected 3 1 3 1 400",
                     lost_cnt_o, lost_o, lost_cnt2, sample_valid_o, sample_o.iaddr);
        end
        sample_ready_i = 1'b1;
        retire(32'h41C);
        tick();
        ivalid_i = 1'b0;
        repeat (5) tick();
        check_got("ovf_out", '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h41C},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        n_tests++;
        if (lost_cnt_o !== 16'd3) begin
            n_fail++;
            $display("FAIL ovf_cnt_kept: cnt=%0d expected 3", lost_cnt_o);
        end
        clr_lost_i = 1'b1;
        tick();
        clr_lost_i = 1'b0;
        n_tests++;
        if (lost_cnt_o !== 16'd0 || lost_o !== 1'b0 || lost_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL ovf_clear: cnt=%0d lost=%b cnt2=%0d expected 0 0 0",
                     lost_cnt_o, lost_o, lost_cnt2);
        end
    endtask

    task automatic test_saturation();
        sample_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            retire(32'h700 + 32'(4 * i));
            tick();
        end
        n_tests++;
        if (lost_cnt_o !== 16'd6 || lost_cnt2 !== 2'd3 || lost2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat: cnt=%0d cnt2=%0d lost2=%b expected 6 3 1", lost_cnt_o, lost_cnt2, lost2);
        end
        clr_lost_i = 1'b1;
        retire(32'h728);
        tick();
        clr_lost_i = 1'b0;
        ivalid_i   = 1'b0;
        n_tests++;
        if (lost_cnt_o !== 16'd1 || lost_o !== 1'b1 || lost_cnt2 !== 2'd1) begin
            n_fail++;
            $display("FAIL clr_with_drop: cnt=%0d lost=%b cnt2=%0d expected 1 1 1",
                     lost_cnt_o, lost_o, lost_cnt2);
        end
        sample_ready_i = 1'b1;
        repeat (4) tick();
        retire(32'h800);
        tick();
        ivalid_i = 1'b0;
        n_tests++;
        if (sample_valid_o !== 1'b1 || sample_o.iaddr !== 32'h800 || sample_o.lost_before !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_kept: valid=%b addr=%h lost_before=%b expected 1 800 1",
                     sample_valid_o, sample_o.iaddr, sample_o.lost_before);
        end
        tick();
    endtask

    task automatic test_exception();
        iexception_i = 1'b1;
        ivalid_i     = 1'b0;
        cause_i      = 5'd2;
        tval_i       = 32'h0000_DEAD;
        iaddr_i      = 32'h600;
        tick();
        iexception_i = 1'b0;
        n_tests++;
        if (sample_valid_o !== 1'b1 || sample_o.exception !== 1'b1 || sample_o.valid !== 1'b0 ||
            sample_o.cause !== 5'd2 || sample_o.tval !== 32'h0000_DEAD || sample_o.iaddr !== 32'h600) begin
            n_fail++;
            $display("FAIL exception: valid=%b exc=%b vbit=%b cause=%0d tval=%h addr=%h expected 1 1 0 2 dead 600",
                     sample_valid_o, sample_o.exception, sample_o.valid, sample_o.cause,
                     sample_o.tval, sample_o.iaddr);
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        sample_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            retire(32'h900 + 32'(4 * i));
            tick();
        end
        ivalid_i = 1'b0;
        n_tests++;
        if (sample_valid_o !== 1'b1 || lost_cnt_o !== 16'd1) begin
            n_fail++;
            $display("FAIL full_before_reset: valid=%b cnt=%0d expected 1 1", sample_valid_o, lost_cnt_o);
        end
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (sample_valid_o !== 1'b0 || state_o !== CAP_IDLE || sample_o !== '0 ||
            lost_o !== 1'b0 || lost_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b state=%0d sample=%h lost=%b cnt=%0d expected 0 0 0 0 0",
                     sample_valid_o, state_o, sample_o, lost_o, lost_cnt_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();
        check_state("post_reset_armed", CAP_ARMED);
        n_tests++;
        if (sample_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_empty: valid=%b expected 0", sample_valid_o);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        {ivalid_i, iexception_i, interrupt_i, compressed_i} = '0;
        cause_i = '0; tval_i = '0; priv_i = 3'd3; iaddr_i = '0; instr_i = '0;
        enable_i = 1'b0; trig_start_en_i = 1'b0; trig_stop_en_i = 1'b0; clr_lost_i = 1'b0;
        trig_start_addr_i = '0; trig_stop_addr_i = '0;
        sample_ready_i = 1'b1;
        tick();
        tick();
        test_reset();
        rst_ni = 1'b1;
        tick();
        test_free_run();
        test_start_trigger();
        test_stop_trigger();
        test_overflow();
        test_saturation();
        test_exception();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
